// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle RV32I main controller and its
// datapath. The controller side uses the master modport; the datapath (or a
// testbench standing in for it) uses the slave modport.
interface multicycle_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [3:0] State;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State, Illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/
// writeback, decodes datapath strobes from the current state and drives the
// ALU operation select.
//
// Optional build macro: CTRL_ILLEGAL_TRAP_EN
//   defined   - unknown opcodes park the FSM in TRAP with Illegal=1 until reset
//   undefined - unknown opcodes fall back to FETCH (NOP); Illegal tied 0
//
// state    | code | meaning
// FETCH    |  0   | read instruction at PC, PC+4 -> PC on MemReady
// DECODE   |  1   | read regs, branch target (OldPC+imm) -> ALUOut
// MEMADR   |  2   | rs1+imm -> ALUOut for load/store
// MEMREAD  |  3   | data read at ALUOut, wait for MemReady
// MEMWB    |  4   | load data -> rd
// MEMWRITE |  5   | store at ALUOut, wait for MemReady
// EXECUTER |  6   | R-type ALU op
// EXECUTEI |  7   | I-type ALU op
// ALUWB    |  8   | ALUOut -> rd
// BRANCH   |  9   | rs1-rs2, take beq/bne from Zero
// JAL      | 10   | OldPC+4 -> ALUOut, target -> PC
// TRAP     | 11   | illegal opcode, held until reset
module multicycle_control_unit #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic                          clk,
    input logic                          reset,
    multicycle_control_unit_if.master    bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    state_t state;
    state_t state_next;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_control;

    // Next-state selection; memory-touching states stall on MemReady.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECUTER;
                    OP_ITYPE:          state_next = EXECUTEI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           state_next = TRAP;
`else
                    default:           state_next = FETCH;
`endif
                endcase
            end
            MEMADR:   state_next = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = bus.MemReady ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = bus.MemReady ? FETCH : MEMWRITE;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL:      state_next = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:     state_next = TRAP;
`else
            TRAP:     state_next = FETCH;
`endif
            default:  state_next = FETCH;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= state_next;
        end
    end

    // Moore decode of datapath selects; FETCH enables and branch PCWrite are
    // gated by live inputs, and all enables are squashed while reset is low.
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = {bus.funct7b5, bus.funct3};
            end
            EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                // Only srai uses Instr[30]; for other I-types it is immediate data.
                alu_control = {bus.funct7b5 & (bus.funct3 == 3'b101), bus.funct3};
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = bus.Zero ^ bus.funct3[0];
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: begin
            end
        endcase
        if (!reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        case (bus.op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.State      = state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.Illegal    = (state == TRAP);
`else
    assign bus.Illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// through its state sequence and checks strobes against hand-derived values.
module tb_multicycle_control_unit;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   ir_pulses;
    logic count_ir;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count IRWrite cycles while a measurement window is open.
    always @(negedge clk) begin
        if (count_ir && bus.IRWrite === 1'b1) ir_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ir_pulses   = 0;
        count_ir    = 1'b0;
        reset       = 1'b0;
        bus.Zero    = 1'b0;
        bus.MemReady = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0);

        // Reset: FETCH, enables forced low even with MemReady high.
        step(); step();
        chk("rst_state", bus.State, 0);
        chk("rst_irwrite", bus.IRWrite, 0);
        chk("rst_pcwrite", bus.PCWrite, 0);
        chk("rst_illegal", bus.Illegal, 0);

        // add
        reset = 1'b1; #1;
        chk("add_fetch_ir", bus.IRWrite, 1);
        chk("add_fetch_pc", bus.PCWrite, 1);
        chk("add_fetch_srcb", bus.ALUSrcB, 2'b10);
        chk("add_fetch_res", bus.ResultSrc, 2'b10);
        step(); chk("add_s1", bus.State, 1);
        chk("add_dec_srca", bus.ALUSrcA, 2'b01);
        chk("add_dec_srcb", bus.ALUSrcB, 2'b01);
        chk("add_dec_regw", bus.RegWrite, 0);
        step(); chk("add_s6", bus.State, 6);
        chk("add_aluctl", bus.ALUControl, 4'b0000);
        chk("add_ex_srca", bus.ALUSrcA, 2'b10);
        chk("add_ex_srcb", bus.ALUSrcB, 2'b00);
        chk("add_ex_regw", bus.RegWrite, 0);
        step(); chk("add_s8", bus.State, 8);
        chk("add_wb_regw", bus.RegWrite, 1);
        chk("add_wb_res", bus.ResultSrc, 2'b00);
        step(); chk("add_s0", bus.State, 0);
        chk("add_end_regw", bus.RegWrite, 0);

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        step(); step(); chk("sub_s6", bus.State, 6);
        chk("sub_aluctl", bus.ALUControl, 4'b1000);
        step(); step(); chk("sub_s0", bus.State, 0);

        // srai
        set_instr(7'b0010011, 3'b101, 1'b1);
        step(); step(); chk("srai_s7", bus.State, 7);
        chk("srai_aluctl", bus.ALUControl, 4'b1101);
        chk("srai_srcb", bus.ALUSrcB, 2'b01);
        step(); chk("srai_s8", bus.State, 8);
        step(); chk("srai_s0", bus.State, 0);

        // addi with Instr[30] set must stay ADD
        set_instr(7'b0010011, 3'b000, 1'b1);
        step(); step(); chk("addi_s7", bus.State, 7);
        chk("addi_aluctl", bus.ALUControl, 4'b0000);
        step(); step(); chk("addi_s0", bus.State, 0);

        // lw with 2 FETCH stalls and 1 MEMREAD stall: 8 cycles total
        set_instr(7'b0000011, 3'b010, 1'b0);
        bus.MemReady = 1'b0; count_ir = 1'b1; ir_pulses = 0; #1;
        chk("lw_stall_ir", bus.IRWrite, 0);
        chk("lw_imm", bus.ImmSrc, 2'b00);
        step(); chk("lw_c1", bus.State, 0);
        step(); chk("lw_c2", bus.State, 0);
        bus.MemReady = 1'b1; #1;
        chk("lw_fetch_ir", bus.IRWrite, 1);
        step(); chk("lw_c3", bus.State, 1);
        step(); chk("lw_c4", bus.State, 2);
        chk("lw_adr_srca", bus.ALUSrcA, 2'b10);
        bus.MemReady = 1'b0;
        step(); chk("lw_c5", bus.State, 3);
        chk("lw_rd_adrsrc", bus.AdrSrc, 1);
        step(); chk("lw_c6", bus.State, 3);
        bus.MemReady = 1'b1;
        step(); chk("lw_c7", bus.State, 4);
        chk("lw_wb_regw", bus.RegWrite, 1);
        chk("lw_wb_res", bus.ResultSrc, 2'b01);
        step(); chk("lw_c8", bus.State, 0);
        count_ir = 1'b0;
        chk("lw_ir_pulses", ir_pulses, 1);

        // beq
        set_instr(7'b1100011, 3'b000, 1'b0);
        step(); chk("beq_imm", bus.ImmSrc, 2'b10);
        step(); chk("beq_s9", bus.State, 9);
        chk("beq_aluctl", bus.ALUControl, 4'b1000);
        bus.Zero = 1'b1; #1; chk("beq_z1", bus.PCWrite, 1);
        bus.Zero = 1'b0; #1; chk("beq_z0", bus.PCWrite, 0);
        step(); chk("beq_s0", bus.State, 0);

        // bne
        set_instr(7'b1100011, 3'b001, 1'b0);
        step(); step(); chk("bne_s9", bus.State, 9);
        bus.Zero = 1'b1; #1; chk("bne_z1", bus.PCWrite, 0);
        bus.Zero = 1'b0; #1; chk("bne_z0", bus.PCWrite, 1);
        step(); chk("bne_s0", bus.State, 0);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        step(); chk("jal_imm", bus.ImmSrc, 2'b11);
        step(); chk("jal_s10", bus.State, 10);
        chk("jal_pcw", bus.PCWrite, 1);
        chk("jal_srca", bus.ALUSrcA, 2'b01);
        chk("jal_srcb", bus.ALUSrcB, 2'b10);
        step(); chk("jal_s8", bus.State, 8);
        step(); chk("jal_s0", bus.State, 0);

        // sw interrupted by reset while stalled in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        step(); chk("sw_imm", bus.ImmSrc, 2'b01);
        step(); chk("sw_s2", bus.State, 2);
        bus.MemReady = 1'b0;
        step(); chk("sw_s5", bus.State, 5);
        chk("sw_memw", bus.MemWrite, 1);
        chk("sw_adrsrc", bus.AdrSrc, 1);
        step(); chk("sw_hold", bus.State, 5);
        chk("sw_hold_memw", bus.MemWrite, 1);
        reset = 1'b0; #1;
        chk("sw_rst_memw", bus.MemWrite, 0);
        chk("sw_rst_state", bus.State, 5);
        step(); chk("sw_rst_s0", bus.State, 0);
        reset = 1'b1; #1;
        chk("rel_ir_low", bus.IRWrite, 0);
        step(); chk("rel_stay", bus.State, 0);
        bus.MemReady = 1'b1; #1;
        chk("rel_ir_high", bus.IRWrite, 1);

        // unrecognised opcode
        set_instr(7'b1111111, 3'b000, 1'b0);
        step(); chk("ill_s1", bus.State, 1);
        step();
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("ill_s11", bus.State, 11);
        chk("ill_flag", bus.Illegal, 1);
        chk("ill_pcw", bus.PCWrite, 0);
        step(); step();
        chk("ill_hold", bus.State, 11);
        chk("ill_hold_flag", bus.Illegal, 1);
        reset = 1'b0;
        step(); chk("ill_rst", bus.State, 0);
        chk("ill_rst_flag", bus.Illegal, 0);
        reset = 1'b1;
`else
        chk("ill_nop_s0", bus.State, 0);
        chk("ill_flag0", bus.Illegal, 0);
        step(); chk("ill_nop_s1", bus.State, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
